// File: rtl/range_scheduler.sv
// Range scheduler: walks the range table, cuts each range into chunks of at most CHUNK values,
// deals them round-robin to the checker lanes and sums the partial results the lanes return.
module range_scheduler #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned CHUNK     = 1024,
    parameter int unsigned ADDR_W    = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W:0]         num_ranges,
    output logic                    tbl_rd_en,
    output logic [ADDR_W-1:0]       tbl_addr,
    input  logic [63:0]             tbl_lo,
    input  logic [63:0]             tbl_hi,
    output logic [NUM_LANES-1:0]    lane_req_valid,
    input  logic [NUM_LANES-1:0]    lane_req_ready,
    output logic [63:0]             lane_req_lo,
    output logic [63:0]             lane_req_hi,
    input  logic [NUM_LANES-1:0]    lane_done,
    input  logic [64*NUM_LANES-1:0] lane_sum,
    output logic                    busy,
    output logic                    finished,
    output logic [63:0]             result
);
    localparam int unsigned RR_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned OUT_W = $clog2(NUM_LANES) + 1;

    typedef enum logic [2:0] {
        StIdle, StFetch, StCapture, StDispatch, StDrain, StDone
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W:0]  idx_q, num_q, idx_inc;
    logic [63:0]      cur_q, hi_q, acc_q, result_q;
    logic [RR_W-1:0]  rr_q, grant_idx, cand;
    logic [OUT_W-1:0] out_q, done_cnt;
    logic [64:0]      ce_wide;
    logic [63:0]      ce, done_sum;
    logic             last_chunk, grant_found, xfer, start_ok;

    assign idx_inc  = idx_q + 1'b1;
    assign start_ok = start && (state_q == StIdle || state_q == StDone);
    assign xfer     = (state_q == StDispatch) && grant_found;

    // Chunk end in 65 bits so a range ending at 2^64-1 cannot wrap back to a small value.
    always_comb begin
        ce_wide    = {1'b0, cur_q} + 65'(CHUNK) - 65'd1;
        last_chunk = ce_wide >= {1'b0, hi_q};
        ce         = last_chunk ? hi_q : ce_wide[63:0];
    end

    // First ready lane at or after the round-robin pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            cand = RR_W'((32'(rr_q) + i) % NUM_LANES);
            if (!grant_found && lane_req_ready[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        done_sum = '0;
        done_cnt = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (lane_done[i]) begin
                done_sum = done_sum + lane_sum[64*i +: 64];
                done_cnt = done_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = (num_ranges == '0) ? StDrain : StFetch;
                end
            end
            StFetch:   state_d = StCapture;
            StCapture: begin
                if (tbl_lo > tbl_hi) begin
                    state_d = (idx_inc < num_q) ? StFetch : StDrain;
                end else begin
                    state_d = StDispatch;
                end
            end
            StDispatch: begin
                if (xfer && last_chunk) begin
                    state_d = (idx_q < num_q) ? StFetch : StDrain;
                end
            end
            StDrain: begin
                if (out_q == '0 && lane_done == '0) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            num_q    <= '0;
            cur_q    <= '0;
            hi_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
            rr_q     <= '0;
            out_q    <= '0;
        end else begin
            out_q <= out_q + OUT_W'(xfer) - done_cnt;
            if (start_ok) begin
                acc_q <= '0;
                idx_q <= '0;
                num_q <= num_ranges;
            end else if (busy) begin
                acc_q <= acc_q + done_sum;
            end
            if (state_q == StCapture) begin
                cur_q <= tbl_lo;
                hi_q  <= tbl_hi;
                idx_q <= idx_inc;
            end
            if (xfer) begin
                rr_q <= RR_W'((32'(grant_idx) + 32'd1) % NUM_LANES);
                if (!last_chunk) begin
                    cur_q <= ce + 64'd1;
                end
            end
            // Drain exits only with no lane_done pending, so acc_q is already final.
            if (state_q == StDrain && state_d == StDone) begin
                result_q <= acc_q;
            end
        end
    end

    always_comb begin
        tbl_rd_en      = (state_q == StFetch);
        tbl_addr       = tbl_rd_en ? idx_q[ADDR_W-1:0] : '0;
        lane_req_valid = '0;
        lane_req_lo    = '0;
        lane_req_hi    = '0;
        if (state_q == StDispatch) begin
            lane_req_lo = cur_q;
            lane_req_hi = ce;
            if (grant_found) begin
                lane_req_valid[grant_idx] = 1'b1;
            end
        end
        busy     = !(state_q == StIdle || state_q == StDone);
        finished = (state_q == StDone);
        result   = result_q;
    end

endmodule

// File: tb/tb_range_scheduler.sv
// Bench for range_scheduler: behavioural lanes and table, chunk scoreboard, result checks.
module tb_range_scheduler;
    localparam int unsigned NL = 2;
    localparam int unsigned CH = 4;
    localparam int unsigned AW = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [AW:0]     num_ranges = '0;
    logic            tbl_rd_en;
    logic [AW-1:0]   tbl_addr;
    logic [63:0]     tbl_lo = '0, tbl_hi = '0;
    logic [NL-1:0]   lane_req_valid;
    logic [NL-1:0]   lane_req_ready = '1;
    logic [63:0]     lane_req_lo, lane_req_hi;
    logic [NL-1:0]   lane_done = '0;
    logic [64*NL-1:0] lane_sum = '0;
    logic            busy, finished;
    logic [63:0]     result;

    range_scheduler #(.NUM_LANES(NL), .CHUNK(CH), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_ranges(num_ranges),
        .tbl_rd_en(tbl_rd_en), .tbl_addr(tbl_addr), .tbl_lo(tbl_lo), .tbl_hi(tbl_hi),
        .lane_req_valid(lane_req_valid), .lane_req_ready(lane_req_ready),
        .lane_req_lo(lane_req_lo), .lane_req_hi(lane_req_hi),
        .lane_done(lane_done), .lane_sum(lane_sum),
        .busy(busy), .finished(finished), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] lo;
        logic [63:0] hi;
    } chunk_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [63:0] tlo [64];
    logic [63:0] thi [64];
    chunk_t      sb_q [$];
    chunk_t      exp_c;

    // Lane model state
    logic        busy_l [NL];
    int          cnt_l [NL];
    int          delay_l [NL];
    logic [63:0] sumv_l [NL];
    logic [63:0] fixed_l [NL];
    logic        sum_mode = 1'b0;

    // Monitor state
    int          mrr = 0;
    int          g;
    logic [NL-1:0] exp_v;
    logic [NL-1:0] xfer_s = '0;
    logic [63:0] xfer_hi_s;
    logic        rd_s = 1'b0;
    logic [AW-1:0] addr_s;
    int          cyc = 0, rd_cnt = 0, valid_cnt = 0, first_rd = -1, first_valid = -1;
    int          dual_done = 0;

    always @(negedge clk) begin
        cyc++;
        xfer_s = '0;
        rd_s   = 1'b0;
        if (!rst) begin
            if (&lane_done) dual_done++;
            if (tbl_rd_en) begin
                check("tbl_addr", 64'(tbl_addr), 64'(rd_cnt));
                rd_s   = 1'b1;
                addr_s = tbl_addr;
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (lane_req_valid != '0) begin
                exp_v = '0;
                g = -1;
                for (int k = 0; k < NL; k++) begin
                    if (g < 0 && lane_req_ready[(mrr + k) % NL]) g = (mrr + k) % NL;
                end
                if (g >= 0) exp_v[g] = 1'b1;
                check("grant", 64'(lane_req_valid), 64'(exp_v));
                if (g >= 0) mrr = (g + 1) % NL;
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
                xfer_s    = lane_req_valid & lane_req_ready;
                xfer_hi_s = lane_req_hi;
                check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    exp_c = sb_q.pop_front();
                    check("chunk_lo", lane_req_lo, exp_c.lo);
                    check("chunk_hi", lane_req_hi, exp_c.hi);
                end
            end
        end
    end

    // Lanes and table respond just after each edge to what the monitor saw before it.
    always @(posedge clk) begin
        logic rst_e;
        rst_e = rst;
        #1;
        for (int i = 0; i < NL; i++) begin
            if (rst_e) begin
                busy_l[i]    = 1'b0;
                lane_done[i] = 1'b0;
            end else if (lane_done[i]) begin
                busy_l[i]    = 1'b0;
                lane_done[i] = 1'b0;
            end else if (xfer_s[i]) begin
                busy_l[i] = 1'b1;
                cnt_l[i]  = delay_l[i] - 1;
                sumv_l[i] = sum_mode ? fixed_l[i] : xfer_hi_s;
            end else if (busy_l[i] && cnt_l[i] == 0) begin
                lane_done[i]          = 1'b1;
                lane_sum[64*i +: 64]  = sumv_l[i];
            end else if (busy_l[i]) begin
                cnt_l[i]--;
            end
            lane_req_ready[i] = !busy_l[i];
        end
        if (!rst_e && rd_s) begin
            tbl_lo = tlo[addr_s];
            tbl_hi = thi[addr_s];
        end
    end

    // Store a range and push the chunks it must produce; returns the sum of chunk ends.
    task automatic load(input int idx, input logic [63:0] lo, input logic [63:0] hi,
                        output logic [63:0] hsum);
        logic [63:0] cur, ce;
        tlo[idx] = lo;
        thi[idx] = hi;
        hsum = '0;
        if (lo <= hi) begin
            cur = lo;
            do begin
                if (hi - cur > 64'(CH - 1)) ce = cur + 64'(CH - 1);
                else ce = hi;
                sb_q.push_back({cur, ce});
                hsum = hsum + ce;
                cur = ce + 64'd1;
            end while (ce != hi);
        end
    endtask

    task automatic kick(input int n);
        num_ranges  = (AW + 1)'(n);
        rd_cnt      = 0;
        valid_cnt   = 0;
        first_rd    = -1;
        first_valid = -1;
        dual_done   = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run(input string tag, input int n, input logic [63:0] exp_res,
                       output int lat);
        kick(n);
        lat = 1;
        while (!finished && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_finished"}, 64'(finished), 64'd1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_sb_left"}, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_finished"}, 64'(finished), 64'd0);
        check({tag, "_result"}, result, 64'd0);
        check({tag, "_rd_en"}, 64'(tbl_rd_en), 64'd0);
        check({tag, "_addr"}, 64'(tbl_addr), 64'd0);
        check({tag, "_valid"}, 64'(lane_req_valid), 64'd0);
        check({tag, "_lo"}, lane_req_lo, 64'd0);
        check({tag, "_hi"}, lane_req_hi, 64'd0);
    endtask

    initial begin
        logic [63:0] s, s2;
        int lat, n;
        for (int i = 0; i < NL; i++) begin
            delay_l[i] = 3;
            fixed_l[i] = '0;
            busy_l[i]  = 1'b0;
            cnt_l[i]   = 0;
            sumv_l[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        rst = 1'b0;

        // One range split into three chunks across lanes 0,1,0
        load(0, 64'd11, 64'd22, s);
        run("t1", 1, s, lat);
        check("t1_expected54", s, 64'd54);
        check("t1_rd_to_offer", 64'(first_valid - first_rd), 64'd2);

        // Empty range skipped, then a single-value range
        load(0, 64'd5, 64'd3, s);
        load(1, 64'd100, 64'd100, s2);
        run("t2", 2, s + s2, lat);
        check("t2_reads", 64'(rd_cnt), 64'd2);
        check("t2_offers", 64'(valid_cnt), 64'd1);

        // No ranges at all
        run("t3", 0, 64'd0, lat);
        check("t3_latency", 64'(lat), 64'd2);
        check("t3_reads", 64'(rd_cnt), 64'd0);
        check("t3_offers", 64'(valid_cnt), 64'd0);

        // Both lanes complete in the same cycle with 5 and 7
        sum_mode   = 1'b1;
        fixed_l[0] = 64'd5;
        fixed_l[1] = 64'd7;
        delay_l[0] = 4;
        delay_l[1] = 3;
        load(0, 64'd1, 64'd8, s);
        run("t4", 1, 64'd12, lat);
        check("t4_dual_done", 64'(dual_done), 64'd1);
        sum_mode   = 1'b0;
        delay_l[0] = 3;

        // Range touching 2^64-1 must not wrap
        load(0, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, s);
        run("t5", 1, s, lat);
        check("t5_offers", 64'(valid_cnt), 64'd1);

        // Abort a long run with reset, then a fresh run
        load(0, 64'd1, 64'd100, s);
        kick(1);
        n = 0;
        while (valid_cnt < 3 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("t6_started", 64'(valid_cnt >= 3), 64'd1);
        rst = 1'b1;
        sb_q.delete();
        mrr = 0;
        @(posedge clk); #1;
        check_reset("t6_rst");
        rst = 1'b0;
        load(0, 64'd1, 64'd8, s);
        run("t6", 1, s, lat);
        check("t6_offers", 64'(valid_cnt), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/range_scheduler.md
Name: range_scheduler

Overview:
- Work scheduler for the repeated-digit ID checker datapath.
- Walks a table of inclusive ranges [lo, hi] and splits each range into chunks of at most CHUNK consecutive values.
- Hands each chunk to one of NUM_LANES checker lanes over a valid/ready handshake, accumulates the per-chunk partial sums the lanes return, and reports the grand total.
- Sits between the range table memory and the parallel checker lanes; replaces the single serial LOAD/NEXT_NUM walk.

Parameters:
- NUM_LANES, 4, number of checker lanes (1..8).
- CHUNK, 1024, maximum values per dispatched chunk (>=1).
- ADDR_W, 6, range table address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- num_ranges  in  ADDR_W+1  number of table entries; sampled on start
- tbl_rd_en  out  1  table read strobe
- tbl_addr  out  ADDR_W  table read address
- tbl_lo  in  64  range low bound; valid the cycle after tbl_rd_en
- tbl_hi  in  64  range high bound; valid the cycle after tbl_rd_en
- lane_req_valid  out  NUM_LANES  one-hot chunk offer
- lane_req_ready  in  NUM_LANES  lane idle and able to accept
- lane_req_lo  out  64  chunk first value; shared by all lanes
- lane_req_hi  out  64  chunk last value, inclusive; shared by all lanes
- lane_done  in  NUM_LANES  one-cycle pulse: lane finished its chunk
- lane_sum  in  64*NUM_LANES  lane i partial sum in bits [64i+63:64i]; valid with lane_done[i]
- busy  out  1  high from start acceptance until DONE
- finished  out  1  high while in DONE
- result  out  64  grand total; valid while finished

Behaviour:
- Reset (rst, synchronous, active-high; clock clk):
  - state=IDLE.
  - tbl_rd_en=0, tbl_addr=0, lane_req_valid=0, lane_req_lo=0, lane_req_hi=0.
  - busy=0, finished=0, result=0, accumulator=0, round-robin pointer=0.
  - Reset mid-run aborts immediately with no further lane requests. Lanes share rst; in-flight lane_done after reset is ignored.
- States: IDLE, FETCH, CAPTURE, DISPATCH, DRAIN, DONE.
- IDLE/DONE:
  - On start: accumulator=0, idx=0, finished=0, busy=1.
  - Go to FETCH, or to DRAIN if num_ranges==0.
  - start in any other state is ignored.
- FETCH: one cycle with tbl_rd_en=1, tbl_addr=idx; next state CAPTURE.
- CAPTURE:
  - Register cur=tbl_lo, hi=tbl_hi; idx+=1.
  - If tbl_lo>tbl_hi, the range is empty and skipped: go to FETCH if idx<num_ranges, else DRAIN.
  - Otherwise go to DISPATCH.
- DISPATCH:
  - Chunk end ce = min(cur+CHUNK-1, hi), computed in 65 bits so there is no wrap at 2^64-1.
  - Drive lane_req_lo=cur, lane_req_hi=ce.
  - Assert valid to exactly one lane: the first ready lane at or after the rr pointer, in circular order.
  - Transfer occurs when valid&ready on that lane. In the same cycle the rr pointer moves to granted+1 mod NUM_LANES.
  - After a transfer: if ce==hi, go to FETCH (more ranges) or DRAIN (none left); else cur=ce+1 and stay in DISPATCH.
  - At most one chunk transfers per cycle.
  - If no lane is ready, lane_req_valid=0 and the scheduler holds.
- Outstanding counter:
  - +1 per transfer; -1 per lane_done bit set.
  - Simultaneous transfer and done(s) in one cycle net correctly.
  - Width is clog2(NUM_LANES)+1 bits.
- Accumulation: every cycle in any state except IDLE/DONE, accumulator += sum of lane_sum[i] over all asserted lane_done[i]. Multiple lanes may complete in the same cycle, and all are added. Arithmetic is modulo 2^64.
- DRAIN: wait until outstanding==0 with no lane_done pending this cycle, then go to DONE.
- DONE:
  - result=accumulator (registered on entry); finished=1, busy=0.
  - Held until start or rst.
- Latency:
  - Table read to first chunk offer: 2 cycles.
  - num_ranges==0: DONE reached 2 cycles after start.
- lane_done from a lane with no outstanding chunk is a protocol violation; behaviour is unspecified, and the bench asserts it never occurs.

Test Plan:
- NUM_LANES=2, CHUNK=4, one range [11,22], lanes always ready and reply after 3 cycles with sum=hi -> chunks [11,14],[15,18],[19,22] go to lanes 0,1,0; result=14+18+22=54.
- Two ranges [5,3] and [100,100] -> first range produces no lane request; single chunk [100,100]; result equals returned sum 100.
- num_ranges=0 -> no tbl_rd_en, no lane requests; finished=1 and result=0 two cycles after start.
- Both lanes pulse lane_done in the same cycle with sums 5 and 7 -> accumulator increases by exactly 12; DONE not entered until both are retired.
- Range [0xFFFFFFFFFFFFFFFD, 0xFFFFFFFFFFFFFFFF], CHUNK=4 -> exactly one chunk with matching lo/hi; scheduler proceeds to DRAIN with no wrap-around re-dispatch.
- rst asserted mid-DISPATCH, then start with range [1,8] -> all outputs return to reset values the next cycle; new run result matches a fresh run, with no carry-over from the aborted run.
